// File: rtl/sp800_90b_health_if.sv
// Sample stream and status bundle between the entropy source, the health
// tests and the downstream NIST test stage.
interface sp800_90b_health_if;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       bit_out;
    logic       bit_out_valid;
    logic       healthy;
    logic       rct_fail;
    logic       apt_fail;
    logic [7:0] fail_count;

    modport master (
        output bit_in, bit_valid, clear,
        input  bit_out, bit_out_valid, healthy, rct_fail, apt_fail, fail_count
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output bit_out, bit_out_valid, healthy, rct_fail, apt_fail, fail_count
    );
endinterface

// File: rtl/sp800_90b_health.sv
// Continuous health tests (repetition count and adaptive proportion) on a
// raw entropy bit stream. Samples are only forwarded once a start-up run of
// clean samples has been seen, and forwarding stops on the first failure
// until a clear restarts the whole start-up sequence.
module sp800_90b_health #(
    parameter int RCT_C     = 21,
    parameter int APT_W     = 512,
    parameter int APT_C     = 410,
    parameter int STARTUP_N = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    sp800_90b_health_if.slave  hif
);

    localparam int WIN_W   = $clog2(APT_W);
    localparam int MATCH_W = WIN_W + 1;

    localparam logic [7:0]         RCT_CV     = 8'(RCT_C);
    localparam logic [MATCH_W-1:0] APT_CV     = MATCH_W'(APT_C);
    localparam logic [16:0]        STARTUP_NV = 17'(STARTUP_N);

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        FAIL    = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         run;
    logic               last_bit;
    logic [WIN_W-1:0]   win_idx;
    logic [MATCH_W-1:0] match;
    logic               ref_bit;
    logic [15:0]        start_cnt;
    logic               bit_out_r;
    logic               bit_out_valid_r;
    logic               rct_fail_r;
    logic               apt_fail_r;
    logic [7:0]         fail_count_r;

    logic               active;
    logic               rct_hit;
    logic               apt_hit;
    logic               any_hit;
    logic [7:0]         run_next;
    logic [MATCH_W-1:0] match_next;
    logic [16:0]        start_next;

    // Next counter values for the current sample and whether it trips a test;
    // run==0 marks the first sample after reset or clear.
    always_comb begin
        active = hif.bit_valid && !hif.clear && (state != FAIL);

        if (run == 8'd0 || hif.bit_in != last_bit)
            run_next = 8'd1;
        else if (run == RCT_CV)
            run_next = run;
        else
            run_next = run + 8'd1;

        if (win_idx == '0)
            match_next = MATCH_W'(1);
        else if (hif.bit_in == ref_bit && match != APT_CV)
            match_next = match + MATCH_W'(1);
        else
            match_next = match;

        rct_hit    = active && (run_next == RCT_CV) && (run != RCT_CV);
        apt_hit    = active && (match_next == APT_CV) && (match != APT_CV);
        any_hit    = rct_hit || apt_hit;
        start_next = {1'b0, start_cnt} + 17'd1;
    end

    // State machine, test counters and registered outputs in one process.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= STARTUP;
            run             <= 8'd0;
            last_bit        <= 1'b0;
            win_idx         <= '0;
            match           <= '0;
            ref_bit         <= 1'b0;
            start_cnt       <= 16'd0;
            bit_out_r       <= 1'b0;
            bit_out_valid_r <= 1'b0;
            rct_fail_r      <= 1'b0;
            apt_fail_r      <= 1'b0;
            fail_count_r    <= 8'd0;
        end else begin
            bit_out_valid_r <= 1'b0;
            if (hif.clear) begin
                state      <= STARTUP;
                rct_fail_r <= 1'b0;
                apt_fail_r <= 1'b0;
                run        <= 8'd0;
                win_idx    <= '0;
                match      <= '0;
                start_cnt  <= 16'd0;
            end else if (active) begin
                run      <= run_next;
                last_bit <= hif.bit_in;
                win_idx  <= win_idx + WIN_W'(1);
                match    <= match_next;
                if (win_idx == '0)
                    ref_bit <= hif.bit_in;

                if (any_hit) begin
                    state      <= FAIL;
                    rct_fail_r <= rct_fail_r | rct_hit;
                    apt_fail_r <= apt_fail_r | apt_hit;
                    if (fail_count_r != 8'hFF)
                        fail_count_r <= fail_count_r + 8'd1;
                end else if (state == STARTUP) begin
                    start_cnt <= start_next[15:0];
                    if (start_next == STARTUP_NV)
                        state <= RUN;
                end else begin
                    bit_out_r       <= hif.bit_in;
                    bit_out_valid_r <= 1'b1;
                end
            end
        end
    end

    assign hif.bit_out       = bit_out_r;
    assign hif.bit_out_valid = bit_out_valid_r;
    assign hif.healthy       = (state == RUN);
    assign hif.rct_fail      = rct_fail_r;
    assign hif.apt_fail      = apt_fail_r;
    assign hif.fail_count    = fail_count_r;

endmodule

// File: tb/tb_sp800_90b_health.sv
// Directed bench for sp800_90b_health with default parameters.
module tb_sp800_90b_health;

    logic clk;
    logic rstn;
    int   tests_run;
    int   tests_failed;

    sp800_90b_health_if hif ();

    sp800_90b_health #(
        .RCT_C     (21),
        .APT_W     (512),
        .APT_C     (410),
        .STARTUP_N (1024)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .hif  (hif)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then wait until just after the next rising edge.
    task automatic applyStimulus(input logic b, input logic v, input logic c);
        hif.bit_in    = b;
        hif.bit_valid = v;
        hif.clear     = c;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Feed n alternating samples starting with 0.
    task automatic sendAlternating(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'(i % 2), 1'b1, 1'b0);
    endtask

    // Directed sequence.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rstn          = 1'b0;
        hif.bit_in    = 1'b0;
        hif.bit_valid = 1'b0;
        hif.clear     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_healthy",   32'(hif.healthy),       32'd0);
        checkOutput("reset_rct",       32'(hif.rct_fail),      32'd0);
        checkOutput("reset_apt",       32'(hif.apt_fail),      32'd0);
        checkOutput("reset_failcount", 32'(hif.fail_count),    32'd0);
        checkOutput("reset_valid",     32'(hif.bit_out_valid), 32'd0);
        checkOutput("reset_bit",       32'(hif.bit_out),       32'd0);
        rstn = 1'b1;

        // Start-up: 1023 clean samples are not enough, the 1024th releases.
        sendAlternating(1023);
        checkOutput("startup_1023_healthy", 32'(hif.healthy), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("startup_1024_healthy", 32'(hif.healthy), 32'd1);
        checkOutput("startup_1024_novalid", 32'(hif.bit_out_valid), 32'd0);

        // First released sample appears one cycle later.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("release_valid", 32'(hif.bit_out_valid), 32'd1);
        checkOutput("release_bit",   32'(hif.bit_out),       32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_valid", 32'(hif.bit_out_valid), 32'd0);

        // RCT failure in RUN on the 21st consecutive 1.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ones_first_valid", 32'(hif.bit_out_valid), 32'd1);
        checkOutput("ones_first_bit",   32'(hif.bit_out),       32'd1);
        for (int i = 0; i < 19; i++)
            applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ones_20_rct",     32'(hif.rct_fail),      32'd0);
        checkOutput("ones_20_healthy", 32'(hif.healthy),       32'd1);
        checkOutput("ones_20_valid",   32'(hif.bit_out_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ones_21_rct",       32'(hif.rct_fail),      32'd1);
        checkOutput("ones_21_apt",       32'(hif.apt_fail),      32'd0);
        checkOutput("ones_21_healthy",   32'(hif.healthy),       32'd0);
        checkOutput("ones_21_novalid",   32'(hif.bit_out_valid), 32'd0);
        checkOutput("ones_21_failcount", 32'(hif.fail_count),    32'd1);

        // FAIL is sticky and suppresses release.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("fail_hold_rct",     32'(hif.rct_fail),      32'd1);
        checkOutput("fail_hold_novalid", 32'(hif.bit_out_valid), 32'd0);
        checkOutput("fail_hold_healthy", 32'(hif.healthy),       32'd0);

        // Clear with a sample present.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("clear1_rct",       32'(hif.rct_fail),   32'd0);
        checkOutput("clear1_apt",       32'(hif.apt_fail),   32'd0);
        checkOutput("clear1_failcount", 32'(hif.fail_count), 32'd1);
        checkOutput("clear1_healthy",   32'(hif.healthy),    32'd0);

        // APT failure in STARTUP: blocks of 19 ones and one 0 trip on sample 431.
        for (int i = 0; i < 430; i++)
            applyStimulus(1'((i % 20) != 19), 1'b1, 1'b0);
        checkOutput("apt_430_apt", 32'(hif.apt_fail), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("apt_431_apt",       32'(hif.apt_fail),   32'd1);
        checkOutput("apt_431_rct",       32'(hif.rct_fail),   32'd0);
        checkOutput("apt_431_failcount", 32'(hif.fail_count), 32'd2);
        checkOutput("apt_431_healthy",   32'(hif.healthy),    32'd0);

        // Clear discards its sample: 1023 more are still not enough.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear2_apt", 32'(hif.apt_fail), 32'd0);
        sendAlternating(1023);
        checkOutput("clear2_1023_healthy", 32'(hif.healthy), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clear2_1024_healthy", 32'(hif.healthy),    32'd1);
        checkOutput("clear2_failcount",    32'(hif.fail_count), 32'd2);

        // Third failure (21 zeros), then back to RUN with fail_count 3.
        for (int i = 0; i < 21; i++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("zeros_rct",       32'(hif.rct_fail),   32'd1);
        checkOutput("zeros_failcount", 32'(hif.fail_count), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        sendAlternating(1024);
        checkOutput("run3_healthy",   32'(hif.healthy),    32'd1);
        checkOutput("run3_failcount", 32'(hif.fail_count), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("run3_valid", 32'(hif.bit_out_valid), 32'd1);

        // Asynchronous reset mid-RUN acts immediately and clears fail_count.
        #3 rstn = 1'b0;
        #1;
        checkOutput("arst_healthy",   32'(hif.healthy),       32'd0);
        checkOutput("arst_valid",     32'(hif.bit_out_valid), 32'd0);
        checkOutput("arst_failcount", 32'(hif.fail_count),    32'd0);
        checkOutput("arst_rct",       32'(hif.rct_fail),      32'd0);
        hif.bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sendAlternating(1023);
        checkOutput("arst_1023_healthy", 32'(hif.healthy), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("arst_1024_healthy", 32'(hif.healthy), 32'd1);

        // Stuck stream with repeated clears: fail_count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 21; i++)
                applyStimulus(1'b1, 1'b1, 1'b0);
            if (k == 254)
                checkOutput("sat_255th", 32'(hif.fail_count), 32'd255);
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkOutput("sat_300th", 32'(hif.fail_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sp800_90b_health.md
SP800_90B_HEALTH -- requirements
Module: sp800_90b_health

Interface
REQ-001 Parameter RCT_C, default 21: repetition-count cutoff, 2..255.
REQ-002 Parameter APT_W, default 512: adaptive-proportion window length in samples, power of two, 16..1024.
REQ-003 Parameter APT_C, default 410: adaptive-proportion cutoff, 2..APT_W.
REQ-004 Parameter STARTUP_N, default 1024: number of clean samples required before release, 1..65535.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 bit_in  in  1  raw entropy bit from the ALFSR digitised output.
REQ-008 bit_valid  in  1  bit_in is a sample this cycle.
REQ-009 clear  in  1  synchronous restart request after failure.
REQ-010 bit_out  out  1  registered copy of an accepted sample, feeding the NIST test stage RND_in.
REQ-011 bit_out_valid  out  1  bit_out carries a released sample this cycle.
REQ-012 healthy  out  1  state is RUN.
REQ-013 rct_fail  out  1  sticky repetition-count failure.
REQ-014 apt_fail  out  1  sticky adaptive-proportion failure.
REQ-015 fail_count  out  8  number of entries into FAIL, saturating.

Function
REQ-016 The block SHALL implement three states: STARTUP, RUN and FAIL.
REQ-017 A sample SHALL count only when bit_valid=1 and clear=0; a cycle with clear=1 SHALL discard any sample.
REQ-018 RCT: the first sample after reset or clear SHALL set last_bit=bit_in and run=1.
REQ-019 RCT: each later sample SHALL set run=run+1 if equal to last_bit, otherwise run=1 and last_bit=bit_in; run SHALL saturate at RCT_C.
REQ-020 RCT: rct_fail SHALL set on the sample whose updated run equals RCT_C.
REQ-021 APT: win_idx SHALL count 0..APT_W-1 and wrap to 0.
REQ-022 APT: at win_idx=0 the sample SHALL set ref=bit_in and match=1; later samples in the window SHALL increment match when bit_in=ref.
REQ-023 APT: apt_fail SHALL set on the sample whose updated match equals APT_C; match SHALL not count past APT_C.
REQ-024 STARTUP SHALL count samples; on the STARTUP_N-th sample with no failure the state SHALL become RUN on the same edge.
REQ-025 STARTUP or RUN SHALL go to FAIL on the edge that sets either fail flag.
REQ-026 When both tests fail on one sample, both flags SHALL set and fail_count SHALL increment by 1 only.
REQ-027 fail_count SHALL saturate at 255.
REQ-028 FAIL SHALL persist while clear=0, and samples in FAIL SHALL not update the RCT or APT counters.
REQ-029 clear in any state SHALL return to STARTUP and zero rct_fail, apt_fail, run, win_idx, match and the startup counter; fail_count SHALL be kept.
REQ-030 bit_out_valid SHALL be high on the cycle after a sample only if the state was RUN before the edge and that sample did not cause a failure; latency SHALL be 1 cycle.
REQ-031 bit_out SHALL hold the last accepted sample, and bit_out_valid SHALL be high for one cycle per released sample.

Reset
REQ-032 While rstn=0 the block SHALL be in STARTUP with all outputs 0 and every counter, last_bit and ref at 0.
REQ-033 rstn=0 asserted mid-operation SHALL take effect immediately and SHALL clear fail_count.
REQ-034 The first sample after rstn is released SHALL be treated as the first RCT sample and win_idx=0.

Verification (defaults)
REQ-035 1024 samples alternating 0,1 -> healthy=1 after the 1024th sample; the 1025th sample gives bit_out_valid=1 one cycle later with bit_out equal to that sample.
REQ-036 In RUN, 21 consecutive 1s -> rct_fail=1 and healthy=0 on the edge of the 21st sample, fail_count=1, and no bit_out_valid for that sample.
REQ-037 In STARTUP, repeated blocks of (19 ones, one 0) from the window start -> apt_fail=1 on sample 431, rct_fail=0, fail_count=1.
REQ-038 In FAIL, pulse clear together with bit_valid -> state STARTUP, both flags 0, fail_count unchanged, the sample discarded, and 1024 further clean samples needed to reach RUN.
REQ-039 rstn=0 mid-RUN with fail_count=3 -> all outputs 0 immediately; after release, 1024 clean samples are needed to reach RUN.
REQ-040 Hold a stuck stream and issue clear 300 times -> fail_count stays at 255.
